// File: rtl/fetch_queue.sv
// Circular {pc, instruction} buffer between fetch and decode. The oldest entry is presented
// show-ahead to the decoder, and a flush empties the queue in a single cycle.
module fetch_queue #(
  parameter int unsigned ADDR  = 32,
  parameter int unsigned INST  = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_e_,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic [INST-1:0] fetch_inst,
  input  logic            stall,
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic [INST-1:0] inst,
  output logic            full,
  output logic            almost_full,
  output logic [CNT-1:0]  count,
  output logic            ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CNT-1:0] DepthC   = CNT'(DEPTH);
  localparam logic [CNT-1:0] DepthM1C = CNT'(DEPTH - 1);

  logic [ADDR-1:0] r_pc   [DEPTH];
  logic [INST-1:0] r_inst [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CNT-1:0]  r_count;
  logic            r_ovf;

  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DepthC);
  // Full refuses enqueue even when a dequeue happens this cycle, so stall never reaches enq.
  assign w_enq   = !fetch_e_ && !w_full && !flush;
  assign w_deq   = !w_empty && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - 1'b1;
      end
      if (!fetch_e_ && w_full) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_pc[r_tail]   <= fetch_pc;
      r_inst[r_tail] <= fetch_inst;
    end
  end

  always_comb begin
    inst_e_ = 1'b1;
    inst_pc = '0;
    inst    = '0;
    if (!w_empty) begin
      inst_e_ = 1'b0;
      inst_pc = r_pc[r_head];
      inst    = r_inst[r_head];
    end
  end

  assign full        = w_full;
  assign almost_full = (r_count >= DepthM1C);
  assign count       = r_count;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-based reference model predicts occupancy
// and flags, and a monitor checks every entry the decoder sees against the expected order.
module tb_fetch_queue;

  localparam int unsigned ADDR  = 32;
  localparam int unsigned INST  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [INST-1:0] inst;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            fetch_e_;
  logic [ADDR-1:0] fetch_pc;
  logic [INST-1:0] fetch_inst;
  logic            stall;
  logic            inst_e_;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            full;
  logic            almost_full;
  logic [CNT-1:0]  count;
  logic            ovf;

  int   n_cmp  = 0;
  int   n_fail = 0;
  ent_t m_q[$];    // reference contents in program order
  ent_t exp_q[$];  // entries the decoder is still owed
  bit   m_ovf = 1'b0;

  fetch_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fetch_e_   (fetch_e_),
    .fetch_pc   (fetch_pc),
    .fetch_inst (fetch_inst),
    .stall      (stall),
    .inst_e_    (inst_e_),
    .inst_pc    (inst_pc),
    .inst       (inst),
    .full       (full),
    .almost_full(almost_full),
    .count      (count),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the decoder sees a valid head, it must be the oldest owed entry.
  always @(negedge clk) begin
    if (!reset && !inst_e_) begin
      if (exp_q.size() == 0) begin
        check("unexpected_head", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("head_pc", 64'(inst_pc), 64'(exp_q[0].pc));
        check("head_inst", 64'(inst), 64'(exp_q[0].inst));
        if (!stall && !flush) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle: drive at posedge+1, check status at negedge, advance model at posedge.
  task automatic step(input bit rst, input bit fl, input bit fen, input logic [ADDR-1:0] pc,
                      input bit st);
    int   n;
    ent_t e;
    reset      = rst;
    flush      = fl;
    fetch_e_   = fen;
    fetch_pc   = pc;
    fetch_inst = $urandom;
    stall      = st;
    e.pc       = pc;
    e.inst     = fetch_inst;
    @(negedge clk);
    n = m_q.size();
    check("count", 64'(count), 64'(n));
    check("inst_e_", 64'(inst_e_), 64'(n == 0));
    check("full", 64'(full), 64'(n == DEPTH));
    check("almost_full", 64'(almost_full), 64'(n >= DEPTH - 1));
    check("ovf", 64'(ovf), 64'(m_ovf));
    if (n == 0) begin
      check("empty_pc", 64'(inst_pc), 64'h0);
      check("empty_inst", 64'(inst), 64'h0);
    end
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      m_q.delete();
      exp_q.delete();
    end else begin
      if (n > 0 && !st) void'(m_q.pop_front());
      if (!fen) begin
        if (n < DEPTH) begin
          m_q.push_back(e);
          exp_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [ADDR-1:0] pc;
    int sent;
    int cyc;
    reset = 1'b1; flush = 1'b0; fetch_e_ = 1'b1; fetch_pc = '0; fetch_inst = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single entry in and out with latency 1.
    step(0, 0, 0, 32'h100, 0);
    step(0, 0, 1, 32'h0, 0);
    step(0, 0, 1, 32'h0, 0);

    // Fill while stalled, then one dropped enqueue.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 32'h200 + 32'(4 * i), 1);
    step(0, 0, 1, 32'h0, 1);
    check("ovf_after_drop", 64'(ovf), 64'h1);
    check("head_held", 64'(inst_pc), 64'h200);

    // Drain from full with fetch held on, across the wrap.
    for (int i = 0; i < 12; i++) step(0, 0, 0, 32'h300 + 32'(4 * i), 0);

    // Flush at count 5 with a fetch in the same cycle.
    step(0, 1, 1, 32'h0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h400 + 32'(4 * i), 1);
    step(0, 1, 0, 32'h4FC, 0);
    step(0, 0, 1, 32'h0, 0);
    check("ovf_survives_flush", 64'(ovf), 64'h1);

    // Stream 20 entries with stall toggling, throttled on almost_full.
    sent = 0;
    cyc  = 0;
    pc   = 32'h1000;
    while ((sent < 20 || m_q.size() != 0) && cyc < 100) begin
      if (sent < 20 && m_q.size() < DEPTH - 1) begin
        step(0, 0, 0, pc, cyc[0]);
        pc = pc + 4;
        sent++;
      end else begin
        step(0, 0, 1, 32'h0, cyc[0]);
      end
      cyc++;
    end
    check("stream_drained", 64'(exp_q.size()), 64'h0);

    // Reset mid-operation at count 4 with a fetch present.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h2000 + 32'(4 * i), 1);
    step(1, 0, 0, 32'h2FFC, 0);
    step(0, 0, 1, 32'h0, 0);

    // Random traffic including drops, flushes and occasional resets.
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
           pc, $urandom_range(0, 2) == 0);
      pc = pc + 4;
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
